mem_io_ctrl: RTL and testbench
==============================

Name: mem_io_ctrl

Overview:
- Memory/IO access sequencer between the LC-3 datapath (MAR, MDR, MDR_In) and the off-chip 16-bit SRAM.
- The control FSM raises Req for one load/store. The block drives the SRAM strobes with a programmable number of wait states, captures read data into MDR_In, and pulses Done.
- Address IO_ADDR is memory-mapped: reads return the switches, writes update the hex-display register. No SRAM cycle is run for it.

Parameters:
- WAIT_STATES, 2, number of cycles OE_n/WE_n is held low per SRAM access; legal range 1..15; 0 is illegal and is rejected at elaboration.
- IO_ADDR, 16'hFFFF, MAR value decoded as the switch/hex IO port.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- Req  in  1  access request; sampled only in IDLE.
- Wr  in  1  1 = write, 0 = read; sampled with Req.
- MAR  in  16  access address.
- MDR  in  16  write data.
- Switches  in  16  IO read source.
- Data_from_SRAM  in  16  SRAM read data.
- MDR_In  out  16  captured read data, held until the next read.
- Done  out  1  one-cycle completion pulse.
- Busy  out  1  high whenever state != IDLE.
- ADDR  out  20  SRAM address, {4'b0, latched MAR}.
- Data_to_SRAM  out  16  latched write data.
- Data_oe  out  1  tristate enable for the SRAM data bus.
- CE_n, OE_n, WE_n, UB_n, LB_n  out  1 each  SRAM strobes, active low.
- Hex_out  out  16  hex-display register.

Behaviour:
- Reset (async, Reset=0):
  - State goes to IDLE.
  - CE_n = OE_n = WE_n = UB_n = LB_n = 1.
  - Data_oe = 0, Done = 0, Busy = 0.
  - MDR_In, Hex_out, ADDR and Data_to_SRAM all = 0.
  - Reset mid-access aborts immediately: strobes return high with no clock, and no Done is produced.
- States: IDLE, SETUP, ACCESS, FINISH. A 4-bit wait counter runs in ACCESS.
- IDLE, on a rising edge with Req = 1:
  - Latch MAR, MDR and Wr.
  - If MAR == IO_ADDR: go to FINISH. On that same edge, a read loads MDR_In <= Switches and a write loads Hex_out <= MDR. The SRAM is not touched and CE_n stays 1.
  - Otherwise: go to SETUP.
- SETUP (1 cycle):
  - CE_n = UB_n = LB_n = 0; ADDR valid; OE_n = WE_n = 1.
  - Write: Data_oe = 1.
  - Next state: ACCESS, with the counter loaded to WAIT_STATES-1.
- ACCESS (WAIT_STATES cycles):
  - CE_n, UB_n, LB_n low.
  - Read: OE_n = 0.
  - Write: WE_n = 0 and Data_oe = 1.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: a read captures MDR_In <= Data_from_SRAM, and the state goes to FINISH.
- FINISH (1 cycle):
  - OE_n = WE_n = 1.
  - CE_n = UB_n = LB_n = 0 for SRAM accesses (data hold); they stay 1 for IO.
  - Write: Data_oe stays 1 for hold time.
  - Done = 1; next state IDLE.
- Strobe outputs are registered (decoded from next state) and glitch-free.
- Latency, counting Req accepted at edge 0:
  - SRAM access: Done is high between edge WAIT_STATES+2 and edge WAIT_STATES+3. With WAIT_STATES = 2 that is between edges 4 and 5.
  - IO access: Done is high between edges 1 and 2.
- Back-to-back operation:
  - Req seen outside IDLE is ignored, not queued.
  - If Req is held high continuously, the next access is accepted on the first edge in IDLE, i.e. the edge after FINISH.
- Stability:
  - MAR/MDR/Wr changes after acceptance do not affect the access in flight.
  - MDR_In changes only on a read capture; Hex_out changes only on an IO write.
- Never asserted together: OE_n = 0 and WE_n = 0; Data_oe = 1 during a read.

Test Plan:
1. SRAM read, MAR = 16'h3000, model returns 16'hBEEF, WAIT_STATES = 2:
   - ADDR = 20'h03000, OE_n low for exactly 2 cycles, WE_n stays 1.
   - MDR_In = 16'hBEEF; Done pulses once between edges 4 and 5.
2. SRAM write, MAR = 16'h0010, MDR = 16'h1234; MDR changed to 16'hFFFF after edge 0:
   - Data_to_SRAM = 16'h1234, WE_n low 2 cycles.
   - Data_oe high through SETUP, ACCESS and FINISH; MDR_In unchanged.
3. IO read, MAR = 16'hFFFF, Switches = 16'h00A5:
   - MDR_In = 16'h00A5 after edge 0, Done between edges 1 and 2.
   - CE_n never low.
4. IO write, MAR = 16'hFFFF, MDR = 16'h0042:
   - Hex_out = 16'h0042, SRAM strobes all high, Done after 1 cycle.
5. Req held high across three reads at WAIT_STATES = 2:
   - Accept edges are 5 edges apart, with exactly three Done pulses.
   - A Req toggle during Busy produces no extra access.
6. Reset driven to 0 mid-ACCESS of a write:
   - WE_n = 1 and Data_oe = 0 asynchronously; Busy = 0; no Done.
   - After release, a fresh read completes normally with correct data.

Source files
------------

// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_ctrl
// Description : Memory/IO access sequencer between the LC-3 datapath
//               (MAR, MDR, MDR_In) and an off-chip 16-bit asynchronous SRAM.
//               One request runs one load or store. SRAM cycles use
//               SETUP -> ACCESS (WAIT_STATES cycles) -> FINISH. The address
//               IO_ADDR is a memory-mapped port: reads return Switches and
//               writes load Hex_out. No SRAM cycle is run for that address.
//
// Ports       : Clk, Reset            - clock (rising edge), async active-low reset
//               Req, Wr, MAR, MDR     - request, direction, address, write data
//               Switches              - IO read source
//               Data_from_SRAM        - SRAM read data
//               MDR_In                - captured read data
//               Done, Busy            - completion pulse, sequencer active
//               ADDR, Data_to_SRAM    - SRAM address and write data
//               Data_oe               - SRAM data bus tristate enable
//               CE_n, OE_n, WE_n,
//               UB_n, LB_n            - SRAM strobes (active low)
//               Hex_out               - hex display register
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MDR_In,
    output logic        Done,
    output logic        Busy,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        Data_oe,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic        UB_n,
    output logic        LB_n,
    output logic [15:0] Hex_out
);

    // A zero wait-state count would leave ACCESS with no strobe cycle, and
    // the counter is only 4 bits wide.
    generate
        if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("mem_io_ctrl: WAIT_STATES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_wr;

    assign Busy = (r_state != S_IDLE);

    // All strobes are assigned on the edge that enters the state they belong
    // to, so they are straight flop outputs. Done is registered from the
    // current state, which places it in the cycle after FINISH.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_wr         <= 1'b0;
            MDR_In       <= 16'h0000;
            Hex_out      <= 16'h0000;
            ADDR         <= 20'h00000;
            Data_to_SRAM <= 16'h0000;
            Done         <= 1'b0;
            Data_oe      <= 1'b0;
            CE_n         <= 1'b1;
            OE_n         <= 1'b1;
            WE_n         <= 1'b1;
            UB_n         <= 1'b1;
            LB_n         <= 1'b1;
        end else begin
            Done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        ADDR         <= {4'b0000, MAR};
                        Data_to_SRAM <= MDR;
                        r_wr         <= Wr;
                        if (MAR == IO_ADDR) begin
                            // IO port: complete on this edge, SRAM untouched
                            r_state <= S_FINISH;
                            if (Wr) begin
                                Hex_out <= MDR;
                            end else begin
                                MDR_In <= Switches;
                            end
                        end else begin
                            r_state <= S_SETUP;
                            CE_n    <= 1'b0;
                            UB_n    <= 1'b0;
                            LB_n    <= 1'b0;
                            Data_oe <= Wr;
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_cnt   <= c_CNT_LOAD;
                    OE_n    <= r_wr;
                    WE_n    <= ~r_wr;
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_FINISH;
                        OE_n    <= 1'b1;
                        WE_n    <= 1'b1;
                        if (!r_wr) begin
                            MDR_In <= Data_from_SRAM;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_FINISH: begin
                    // Chip enable and write data were held through FINISH
                    // for SRAM hold time; release them on the way to IDLE.
                    r_state <= S_IDLE;
                    CE_n    <= 1'b1;
                    UB_n    <= 1'b1;
                    LB_n    <= 1'b1;
                    Data_oe <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_ctrl
// Description : Self-checking bench for mem_io_ctrl. A behavioural model
//               predicts each access's cycle profile (Done position, strobe
//               cycle counts) and the architectural registers MDR_In and
//               Hex_out from the access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_ctrl;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        Wr;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Switches;
    logic [15:0] Data_from_SRAM;
    logic [15:0] MDR_In;
    logic        Done;
    logic        Busy;
    logic [19:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        Data_oe;
    logic        CE_n;
    logic        OE_n;
    logic        WE_n;
    logic        UB_n;
    logic        LB_n;
    logic [15:0] Hex_out;

    mem_io_ctrl #(
        .WAIT_STATES (WS),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Req            (Req),
        .Wr             (Wr),
        .MAR            (MAR),
        .MDR            (MDR),
        .Switches       (Switches),
        .Data_from_SRAM (Data_from_SRAM),
        .MDR_In         (MDR_In),
        .Done           (Done),
        .Busy           (Busy),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_oe        (Data_oe),
        .CE_n           (CE_n),
        .OE_n           (OE_n),
        .WE_n           (WE_n),
        .UB_n           (UB_n),
        .LB_n           (LB_n),
        .Hex_out        (Hex_out)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [15:0] exp_mdr_in;
    logic [15:0] exp_hex;

    // Observations of the last access
    logic [7:0]  o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe, o_viol;
    logic [15:0] o_mdr_in0;

    // Expected profile {done count, Done interval, OE_n-low cycles,
    // WE_n-low cycles, CE_n-low cycles, Data_oe cycles}. Interval k means
    // the output is high between edge k and edge k+1, edge 0 = acceptance.
    function automatic logic [47:0] profile(input logic wr, input logic [15:0] mar);
        logic       io;
        logic [7:0] n_sram;
        io     = (mar == 16'hFFFF);
        n_sram = io ? 8'd0 : 8'(WS + 2);
        return {8'd1,
                io ? 8'd1 : 8'(WS + 2),
                (!io && !wr) ? 8'(WS) : 8'd0,
                (!io &&  wr) ? 8'(WS) : 8'd0,
                n_sram,
                wr ? n_sram : 8'd0};
    endfunction

    task automatic model_update(input logic wr, input logic [15:0] mar,
                                input logic [15:0] mdr, input logic [15:0] rdata);
        if (!wr) exp_mdr_in = (mar == 16'hFFFF) ? Switches : rdata;
        else if (mar == 16'hFFFF) exp_hex = mdr;
    endtask

    // Issues one access, scrambles MAR/MDR/Wr right after acceptance, and
    // records 12 cycles of outputs.
    task automatic run_access(input logic wr, input logic [15:0] mar,
                              input logic [15:0] mdr, input logic [15:0] rdata);
        o_done_cnt = 0; o_done_edge = 8'hFF; o_oe = 0; o_we = 0;
        o_ce = 0; o_doe = 0; o_viol = 0;
        @(negedge Clk);
        Req = 1'b1; Wr = wr; MAR = mar; MDR = mdr; Data_from_SRAM = rdata;
        @(posedge Clk); #1;
        Req = 1'b0; Wr = ~wr; MAR = ~mar; MDR = ~mdr;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) o_mdr_in0 = MDR_In;
            if (Done) begin o_done_cnt++; o_done_edge = 8'(i); end
            if (!OE_n) o_oe++;
            if (!WE_n) o_we++;
            if (!CE_n) o_ce++;
            if (Data_oe) o_doe++;
            if ((!OE_n && !WE_n) || (Data_oe && !wr) || UB_n !== CE_n || LB_n !== CE_n)
                o_viol++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0; Req = 1'b0; Wr = 1'b0; MAR = 16'h0; MDR = 16'h0;
        Switches = 16'h0; Data_from_SRAM = 16'h0;
        #12;
        total++;
        if ({CE_n, OE_n, WE_n, UB_n, LB_n, Data_oe, Done, Busy} !== 8'b11111000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 11111000",
                     {CE_n, OE_n, WE_n, UB_n, LB_n, Data_oe, Done, Busy});
        end
        total++;
        if ({MDR_In, Hex_out, ADDR, Data_to_SRAM} !== 68'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {MDR_In, Hex_out, ADDR, Data_to_SRAM});
        end
        @(negedge Clk); Reset = 1'b1;
        exp_mdr_in = 16'h0; exp_hex = 16'h0;
    endtask

    task automatic test_sram_read;
        run_access(1'b0, 16'h3000, 16'h0, 16'hBEEF);
        model_update(1'b0, 16'h3000, 16'h0, 16'hBEEF);
        total++;
        if ({o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe} !== profile(1'b0, 16'h3000)) begin
            bad++;
            $display("FAIL sram_read_profile: got %h want %h",
                     {o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe}, profile(1'b0, 16'h3000));
        end
        total++;
        if (MDR_In !== exp_mdr_in) begin
            bad++; $display("FAIL sram_read_data: got %h want %h", MDR_In, exp_mdr_in);
        end
        total++;
        if (ADDR !== 20'h03000) begin
            bad++; $display("FAIL sram_read_addr: got %h want 03000", ADDR);
        end
        total++;
        if (o_viol !== 8'd0) begin
            bad++; $display("FAIL sram_read_strobes: got %0d violations want 0", o_viol);
        end
    endtask

    task automatic test_sram_write;
        run_access(1'b1, 16'h0010, 16'h1234, 16'h0);
        model_update(1'b1, 16'h0010, 16'h1234, 16'h0);
        total++;
        if ({o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe} !== profile(1'b1, 16'h0010)) begin
            bad++;
            $display("FAIL sram_write_profile: got %h want %h",
                     {o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe}, profile(1'b1, 16'h0010));
        end
        total++;
        if ({Data_to_SRAM, ADDR} !== {16'h1234, 20'h00010}) begin
            bad++; $display("FAIL sram_write_latch: got %h want 123400010", {Data_to_SRAM, ADDR});
        end
        total++;
        if ({MDR_In, Hex_out} !== {exp_mdr_in, exp_hex}) begin
            bad++; $display("FAIL sram_write_regs: got %h want %h", {MDR_In, Hex_out}, {exp_mdr_in, exp_hex});
        end
        total++;
        if (o_viol !== 8'd0) begin
            bad++; $display("FAIL sram_write_strobes: got %0d violations want 0", o_viol);
        end
    endtask

    task automatic test_io_read;
        Switches = 16'h00A5;
        run_access(1'b0, 16'hFFFF, 16'h0, 16'h7777);
        model_update(1'b0, 16'hFFFF, 16'h0, 16'h7777);
        total++;
        if (o_mdr_in0 !== 16'h00A5) begin
            bad++; $display("FAIL io_read_edge0: got %h want 00a5", o_mdr_in0);
        end
        total++;
        if ({o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe} !== profile(1'b0, 16'hFFFF)) begin
            bad++;
            $display("FAIL io_read_profile: got %h want %h",
                     {o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe}, profile(1'b0, 16'hFFFF));
        end
        total++;
        if (MDR_In !== exp_mdr_in) begin
            bad++; $display("FAIL io_read_data: got %h want %h", MDR_In, exp_mdr_in);
        end
    endtask

    task automatic test_io_write;
        run_access(1'b1, 16'hFFFF, 16'h0042, 16'h0);
        model_update(1'b1, 16'hFFFF, 16'h0042, 16'h0);
        total++;
        if ({o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe} !== profile(1'b1, 16'hFFFF)) begin
            bad++;
            $display("FAIL io_write_profile: got %h want %h",
                     {o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe}, profile(1'b1, 16'hFFFF));
        end
        total++;
        if ({Hex_out, MDR_In} !== {exp_hex, exp_mdr_in}) begin
            bad++; $display("FAIL io_write_regs: got %h want %h", {Hex_out, MDR_In}, {exp_hex, exp_mdr_in});
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        int dones;
        logic prev_busy;
        dones = 0; prev_busy = 1'b0;
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b0; MAR = 16'h2000; Data_from_SRAM = 16'hC0DE;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk); #1;
            if (Busy && !prev_busy) acc.push_back(i);
            prev_busy = Busy;
            if (Done) dones++;
            if (acc.size() == 1 && i == acc[0] + 1) Req = 1'b0;
            if (acc.size() == 1 && i == acc[0] + 2) Req = 1'b1;
            if (acc.size() >= 3) Req = 1'b0;
        end
        exp_mdr_in = 16'hC0DE;
        total++;
        if (acc.size() != 3 || dones != 3) begin
            bad++; $display("FAIL b2b_count: got accepts=%0d dones=%0d want 3 3", acc.size(), dones);
        end else begin
            total++;
            if (acc[1] - acc[0] != WS + 3 || acc[2] - acc[1] != WS + 3) begin
                bad++; $display("FAIL b2b_spacing: got %0d %0d want %0d", acc[1] - acc[0],
                                acc[2] - acc[1], WS + 3);
            end
        end
        total++;
        if (MDR_In !== exp_mdr_in) begin
            bad++; $display("FAIL b2b_data: got %h want %h", MDR_In, exp_mdr_in);
        end
    endtask

    task automatic test_reset_mid_access;
        int dones;
        logic [15:0] rd;
        dones = 0;
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; MAR = 16'h0100; MDR = 16'h5555;
        @(posedge Clk); #1; Req = 1'b0;
        @(posedge Clk);
        @(posedge Clk); #3;
        total++;
        if (WE_n !== 1'b0) begin
            bad++; $display("FAIL rst_mid_pre: got WE_n=%b want 0", WE_n);
        end
        Reset = 1'b0;
        #1;
        total++;
        if ({WE_n, Data_oe, Busy, CE_n, Done} !== 5'b10010) begin
            bad++; $display("FAIL rst_mid_async: got %b want 10010", {WE_n, Data_oe, Busy, CE_n, Done});
        end
        exp_mdr_in = 16'h0; exp_hex = 16'h0;
        @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        total++;
        if (dones != 0 || {MDR_In, Hex_out} !== {exp_mdr_in, exp_hex}) begin
            bad++; $display("FAIL rst_mid_after: got dones=%0d regs=%h want 0 %h", dones,
                            {MDR_In, Hex_out}, {exp_mdr_in, exp_hex});
        end
        rd = 16'($urandom);
        run_access(1'b0, 16'h0200, 16'h0, rd);
        model_update(1'b0, 16'h0200, 16'h0, rd);
        total++;
        if ({o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe, MDR_In} !==
            {profile(1'b0, 16'h0200), exp_mdr_in}) begin
            bad++;
            $display("FAIL rst_mid_fresh_read: got %h want %h",
                     {o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe, MDR_In},
                     {profile(1'b0, 16'h0200), exp_mdr_in});
        end
    endtask

    task automatic test_random;
        logic        wr;
        logic [15:0] mar, mdr, rd;
        for (int n = 0; n < 20; n++) begin
            wr  = 1'($urandom);
            mar = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            mdr = 16'($urandom);
            rd  = 16'($urandom);
            Switches = 16'($urandom);
            run_access(wr, mar, mdr, rd);
            model_update(wr, mar, mdr, rd);
            total++;
            if ({o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe} !== profile(wr, mar) ||
                o_viol !== 8'd0) begin
                bad++;
                $display("FAIL rand_profile[%0d]: got %h viol=%0d want %h viol=0", n,
                         {o_done_cnt, o_done_edge, o_oe, o_we, o_ce, o_doe}, o_viol, profile(wr, mar));
            end
            total++;
            if ({MDR_In, Hex_out, ADDR, Data_to_SRAM} !== {exp_mdr_in, exp_hex, 4'h0, mar, mdr}) begin
                bad++;
                $display("FAIL rand_regs[%0d]: got %h want %h", n,
                         {MDR_In, Hex_out, ADDR, Data_to_SRAM}, {exp_mdr_in, exp_hex, 4'h0, mar, mdr});
            end
        end
    endtask

    initial begin
        test_reset;
        test_sram_read;
        test_sram_write;
        test_io_read;
        test_io_write;
        test_back_to_back;
        test_reset_mid_access;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
